// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency, single-port word memory between the fetch port and
// the data port. Data wins arbitration unless fetch has been held off too long.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ready,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // lat_cnt is 1 in the strobe cycle, so read data is due when it hits LATENCY+1
    localparam logic [4:0] LAT_END    = 5'(LATENCY + 1);
    localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);
    localparam logic       OWNER_I    = 1'b0;
    localparam logic       OWNER_D    = 1'b1;

    state_t              state_q;
    logic                owner_q;
    logic                store_q;
    logic [4:0]          lat_cnt_q;
    logic [3:0]          starve_q;
    logic                i_ready_q;
    logic                d_ready_q;
    logic [31:0]         i_rdata_q;
    logic [31:0]         d_rdata_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                busy_q;

    logic starved;
    logic grant_data;
    logic grant_fetch;
    logic addr_bits_unused;

    assign starved     = i_req && (starve_q == STARVE_TOP);
    assign grant_data  = d_req && !starved;
    assign grant_fetch = !grant_data && i_req;

    // Byte-lane and out-of-range address bits are silently dropped.
    assign addr_bits_unused = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWNER_I;
            store_q     <= 1'b0;
            lat_cnt_q   <= '0;
            starve_q    <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_data || grant_fetch) begin
                        state_q     <= S_ACCESS;
                        busy_q      <= 1'b1;
                        lat_cnt_q   <= 5'd1;
                        owner_q     <= grant_data ? OWNER_D : OWNER_I;
                        store_q     <= grant_data && d_we;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_data && d_we;
                        mem_addr_q  <= grant_data ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
                        mem_wdata_q <= d_wdata;
                        if (grant_data && i_req)
                            starve_q <= (starve_q == STARVE_TOP) ? starve_q : starve_q + 4'd1;
                        else
                            starve_q <= '0;
                    end
                end
                S_ACCESS: begin
                    lat_cnt_q <= lat_cnt_q + 5'd1;
                    if (lat_cnt_q == LAT_END) begin
                        state_q <= S_DONE;
                        if (owner_q == OWNER_D) begin
                            d_ready_q <= 1'b1;
                            if (!store_q)
                                d_rdata_q <= mem_rdata;
                        end else begin
                            i_ready_q <= 1'b1;
                            i_rdata_q <= mem_rdata;
                        end
                    end
                end
                S_DONE: begin
                    // Requests seen here are ignored so a held request is not granted twice.
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    lat_cnt_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the driver queues hand-computed expected
// memory strobes and ready pulses; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 10;
    localparam int LAT        = 2;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_req = 1'b0;
    logic [31:0]       i_addr = '0;
    logic              i_ready;
    logic [31:0]       i_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [31:0]       d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic              d_ready;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              busy;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LATENCY(LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-latency memory; poison value shows up outside the valid read cycle.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] pipe [0:LAT-1];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int k = 0; k < (1<<ADDR_W); k++) mem[k] <= '0;
            mem[0]     <= 32'h0000_0013;
            mem[4]     <= 32'h2408_0005;
            mem[16]    <= 32'h1111_0016;
            mem_loaded <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        pipe[0] <= mem_en ? mem[mem_addr] : 32'hBAD0_BAD0;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[LAT-1];

    typedef struct {
        int          cyc;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic        port;
        logic [31:0] irdata;
        logic [31:0] drdata;
    } rdy_exp_t;

    mem_exp_t    mq[$];
    rdy_exp_t    rq[$];
    logic [31:0] exp_i_last = '0;
    logic [31:0] exp_d_last = '0;
    int          timeout_cnt = 0;
    logic        tb_done = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // c = cycle in which the request is first seen by an idle arbiter.
    task automatic expect_acc(input int c, input logic port, input logic we,
                              input logic [9:0] waddr, input logic [31:0] wdata,
                              input logic [31:0] rdata);
        mem_exp_t m;
        rdy_exp_t r;
        m.cyc = c + 1; m.we = we; m.addr = waddr; m.wdata = wdata;
        mq.push_back(m);
        if (port == 1'b0) exp_i_last = rdata;
        else if (!we) exp_d_last = rdata;
        r.cyc = c + LAT + 2; r.port = port; r.irdata = exp_i_last; r.drdata = exp_d_last;
        rq.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input logic port, input int budget);
        int n = 0;
        while (!(port ? d_ready : i_ready) && n < budget) begin
            tick();
            n++;
        end
        if (!(port ? d_ready : i_ready)) begin
            timeout_cnt++;
            $display("FAIL wait_ready port=%0d no ready after %0d cycles, required ready=1", port, budget);
        end
    endtask

    initial begin
        int c;
        mem_exp_t m;
        // Reset held with both requests pending, then data wins first.
        i_req = 1'b1; i_addr = 32'h0000_0000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
        repeat (3) tick();
        rst = 1'b1;
        c = cyc;
        expect_acc(c,     1'b1, 1'b0, 10'd16, 32'h0, 32'h1111_0016);
        expect_acc(c + 5, 1'b0, 1'b0, 10'd0,  32'h0, 32'h0000_0013);
        wait_rdy(1'b1, 20); d_req = 1'b0;
        wait_rdy(1'b0, 20); i_req = 1'b0;
        tick();

        // Single fetch.
        c = cyc;
        i_req = 1'b1; i_addr = 32'h0000_0010;
        expect_acc(c, 1'b0, 1'b0, 10'd4, 32'h0, 32'h2408_0005);
        wait_rdy(1'b0, 20); i_req = 1'b0;
        tick();

        // Store; request fields change after the grant, fetch pulses and drops while busy.
        c = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0020; d_wdata = 32'hDEAD_BEEF;
        expect_acc(c, 1'b1, 1'b1, 10'd8, 32'hDEAD_BEEF, 32'h0);
        tick();
        d_addr = 32'h0000_03FC; d_wdata = 32'h0BAD_F00D; i_req = 1'b1;
        tick();
        i_req = 1'b0;
        wait_rdy(1'b1, 20); d_req = 1'b0; d_we = 1'b0;
        tick();

        // Load back with junk in the ignored address bits.
        c = cyc;
        d_req = 1'b1; d_addr = 32'hFFFF_F023;
        expect_acc(c, 1'b1, 1'b0, 10'd8, 32'h0, 32'hDEAD_BEEF);
        wait_rdy(1'b1, 20); d_req = 1'b0;
        tick();

        // Starvation: two rounds of 4 data grants followed by one fetch grant.
        c = cyc;
        i_req = 1'b1; i_addr = 32'h0000_0010;
        d_req = 1'b1; d_addr = 32'h0000_0040;
        for (int k = 0; k < 4; k++) expect_acc(c + 5*k, 1'b1, 1'b0, 10'd16, 32'h0, 32'h1111_0016);
        expect_acc(c + 20, 1'b0, 1'b0, 10'd4, 32'h0, 32'h2408_0005);
        for (int k = 0; k < 4; k++) expect_acc(c + 25 + 5*k, 1'b1, 1'b0, 10'd16, 32'h0, 32'h1111_0016);
        expect_acc(c + 45, 1'b0, 1'b0, 10'd4, 32'h0, 32'h2408_0005);
        repeat (49) tick();
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // Reset one cycle after the strobe: no ready, then the held fetch is re-granted.
        c = cyc;
        i_req = 1'b1; i_addr = 32'h0000_0010;
        m.cyc = c + 1; m.we = 1'b0; m.addr = 10'd4; m.wdata = 32'h0;
        mq.push_back(m);
        tick();
        tick();
        rst = 1'b0;
        exp_i_last = '0; exp_d_last = '0;
        tick();
        tick();
        rst = 1'b1;
        expect_acc(c + 4, 1'b0, 1'b0, 10'd4, 32'h0, 32'h2408_0005);
        wait_rdy(1'b0, 20); i_req = 1'b0;
        tick();
        tick();
        tb_done = 1'b1;
    end

    rdy_exp_t mon_r;
    mem_exp_t mon_m;
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ({busy, mem_en, mem_we, i_ready, d_ready} !== 5'b0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got busy=%b en=%b we=%b ir=%b dr=%b irdata=%h drdata=%h, required all 0",
                         cyc, busy, mem_en, mem_we, i_ready, d_ready, i_rdata, d_rdata);
            end
        end
        if (mem_en) begin
            checks++;
            if (mq.size() == 0) begin
                errors++;
                $display("FAIL mem_strobe cyc=%0d got unexpected strobe addr=%0d we=%b, required none", cyc, mem_addr, mem_we);
            end else begin
                mon_m = mq.pop_front();
                if (cyc != mon_m.cyc || mem_we !== mon_m.we || mem_addr !== mon_m.addr ||
                    (mon_m.we && mem_wdata !== mon_m.wdata)) begin
                    errors++;
                    $display("FAIL mem_strobe got cyc=%0d we=%b addr=%0d wdata=%h, required cyc=%0d we=%b addr=%0d wdata=%h",
                             cyc, mem_we, mem_addr, mem_wdata, mon_m.cyc, mon_m.we, mon_m.addr, mon_m.wdata);
                end
            end
        end else begin
            checks++;
            if (mem_we) begin
                errors++;
                $display("FAIL mem_we_qualified cyc=%0d got mem_we=1 with mem_en=0, required 0", cyc);
            end
        end
        if (i_ready || d_ready) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL ready_pulse cyc=%0d got unexpected ir=%b dr=%b, required none", cyc, i_ready, d_ready);
            end else begin
                mon_r = rq.pop_front();
                if (cyc != mon_r.cyc || i_ready !== !mon_r.port || d_ready !== mon_r.port ||
                    i_rdata !== mon_r.irdata || d_rdata !== mon_r.drdata || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_pulse got cyc=%0d ir=%b dr=%b irdata=%h drdata=%h busy=%b, required cyc=%0d port=%0d irdata=%h drdata=%h busy=1",
                             cyc, i_ready, d_ready, i_rdata, d_rdata, busy,
                             mon_r.cyc, mon_r.port, mon_r.irdata, mon_r.drdata);
                end
            end
        end
        if (tb_done) begin
            checks++;
            if (rq.size() != 0 || mq.size() != 0 || timeout_cnt != 0) begin
                errors++;
                $display("FAIL end_of_test got pending_ready=%0d pending_strobe=%0d timeouts=%0d, required 0 0 0",
                         rq.size(), mq.size(), timeout_cnt);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port, fixed-latency word memory between the instruction-fetch port and the data-memory port of the 5-stage pipeline.
- The CPU can then run from one unified memory instead of separate IM/DM.
- Runs a per-access state machine and returns one-cycle ready pulses. The CPU uses a low ready as its IF or MEM stall condition.
- Data accesses have priority. A starvation counter bounds how long fetch can be held off.

Parameters:
ADDR_W, 10, memory word-address width; mem_addr = byte_addr[ADDR_W+1:2]
LATENCY, 2, cycles from mem_en high to mem_rdata valid; legal range 1..15
STARVE_MAX, 4, maximum consecutive data grants while i_req is pending; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
i_req  in  1  fetch request; held high until i_ready
i_addr  in  32  fetch byte address
i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  out  32  fetched instruction, registered
d_req  in  1  data request; held high until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_ready  out  1  one-cycle pulse: data access complete
d_rdata  out  32  load data, registered
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid LATENCY cycles after mem_en
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst=0, asynchronous): all outputs go to 0; state=IDLE; owner=I; lat_cnt=0; starve_cnt=0.
- Outputs are all registered; none is combinational from an input.
- States:
  - IDLE: arbitration happens here only.
  - ACCESS: lat_cnt counts up from 1.
  - DONE: one cycle.
- IDLE grant rule, evaluated at the clock edge:
  - If d_req=1 and NOT (i_req=1 and starve_cnt==STARVE_MAX): grant D.
  - Else if i_req=1: grant I.
  - Else: stay in IDLE.
- On a grant:
  - Latch owner. Next cycle (G): mem_en=1, mem_addr=addr[ADDR_W+1:2], mem_we=d_we for a D grant (0 for I), mem_wdata=d_wdata.
  - State goes to ACCESS with lat_cnt=1.
  - mem_en and mem_we are high for cycle G only. mem_addr and mem_wdata hold until the next grant.
- ACCESS:
  - Increment lat_cnt each cycle.
  - In cycle G+LATENCY, capture mem_rdata into the owner's rdata register (skipped for stores) and go to DONE.
- DONE (cycle G+LATENCY+1):
  - The owner's ready is 1 for exactly this cycle; the other port's ready stays 0.
  - Next state is IDLE. Requests sampled during DONE are ignored, which prevents a double grant on a held request.
- Timing:
  - Request first visible in IDLE cycle 0 -> ready in cycle LATENCY+2.
  - Back-to-back access period is LATENCY+3 cycles.
- The non-owner's rdata register holds its last value; d_rdata is unchanged by stores.
- starve_cnt:
  - On a D grant while i_req=1: increment, saturating at STARVE_MAX.
  - On an I grant, or on a D grant with i_req=0: clear to 0.
- The rdata address/data inputs are sampled only at the grant edge. Later changes in the request fields are ignored until ready.
- A request dropped before its grant is never served. A request dropped after its grant still completes, and the ready pulse is still issued.
- Byte-address bits [1:0] and bits above ADDR_W+1 are ignored, with no error signalled.
- Reset mid-access: the in-flight access is abandoned, no ready is issued, and state=IDLE. The memory may still complete an already-strobed write.
- Simultaneous i_req and d_req with starve_cnt < STARVE_MAX: D wins.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both requests high -> mem_en, i_ready, d_ready, busy all 0. After release, first mem_en in cycle 1.
- Single fetch, LATENCY=2: i_req=1, i_addr=0x0000_0010 at cycle 0 -> mem_en=1, mem_addr=4 in cycle 1. Memory returns 0x2408_0005 in cycle 3 -> i_ready=1, i_rdata=0x2408_0005 in cycle 4 only.
- Store then load at 0x20: store d_wdata=0xDEAD_BEEF -> mem_we=1 for one cycle, d_ready 4 cycles after the grant edge. Load -> d_rdata=0xDEAD_BEEF; i_rdata unchanged.
- Priority: i_req and d_req raised in the same cycle -> D granted first, then I granted on the following IDLE. Both readies arrive, 5 cycles apart at LATENCY=2.
- Starvation, STARVE_MAX=4: i_req held with d_req held continuously -> exactly 4 D grants, then an I grant, then starve_cnt=0.
- Reset mid-access: assert rst=0 in cycle G+1 -> no ready pulse. After release, the still-held request is re-granted and completes normally.
